// File: rtl/channel_serializer_if.sv
// Input-side word handshake for channel_serializer: one INPUT_NUM-lane word per transfer.
interface channel_serializer_if #(
  parameter int INPUT_NUM  = 8,
  parameter int WORD_WIDTH = 8
);
  logic                            s_vld;
  logic                            s_rdy;
  logic [INPUT_NUM*WORD_WIDTH-1:0] s_data;

  modport master (output s_vld, output s_data, input s_rdy);
  modport slave  (input s_vld, input s_data, output s_rdy);
endinterface

// File: rtl/channel_serializer.sv
// Parallel channel words in, LSB-first digit streams out (all lanes in lockstep),
// with guard-bit extension so the downstream digit-serial adder tree cannot overflow.
module channel_serializer #(
  parameter int INPUT_NUM        = 8,
  parameter int INPUT_DATA_WIDTH = 2,
  parameter int WORD_WIDTH       = 8,
  parameter int SIGNED           = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  clk_en,
  channel_serializer_if.slave                   s_if,
  output logic [INPUT_NUM*INPUT_DATA_WIDTH-1:0] dout,
  output logic                                  dout_vld,
  output logic                                  first_dout_vld,
  output logic                                  last_dout_vld,
  output logic                                  busy
);

  localparam int GUARD  = $clog2(INPUT_NUM);
  localparam int DIGITS = (WORD_WIDTH + GUARD + INPUT_DATA_WIDTH - 1) / INPUT_DATA_WIDTH;
  localparam int LANE_W = DIGITS * INPUT_DATA_WIDTH;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {LD_NONE, LD_BYPASS, LD_HOLD} load_t;

  state_t                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             hold_full_q, hold_full_d;
  load_t                            load_sel;
  logic                             do_shift;
  logic                             hold_wr;
  logic                             xfer;
  logic [INPUT_NUM*LANE_W-1:0]      sreg_p0;
  logic [INPUT_NUM*WORD_WIDTH-1:0]  hold_p0;

  // Widen every lane to LANE_W bits; guard bits are zero or copies of the lane MSB.
  function automatic logic [INPUT_NUM*LANE_W-1:0] extend_word(
    input logic [INPUT_NUM*WORD_WIDTH-1:0] w
  );
    logic [INPUT_NUM*LANE_W-1:0] r;
    logic signed [WORD_WIDTH-1:0] lane;
    r = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      lane = w[i*WORD_WIDTH +: WORD_WIDTH];
      if (SIGNED != 0) r[i*LANE_W +: LANE_W] = LANE_W'(lane);
      else             r[i*LANE_W +: LANE_W] = LANE_W'($unsigned(lane));
    end
    return r;
  endfunction

  function automatic logic [INPUT_NUM*LANE_W-1:0] shift_lanes(
    input logic [INPUT_NUM*LANE_W-1:0] s
  );
    logic [INPUT_NUM*LANE_W-1:0] r;
    r = '0;
    for (int i = 0; i < INPUT_NUM; i++)
      r[i*LANE_W +: LANE_W] = s[i*LANE_W +: LANE_W] >> INPUT_DATA_WIDTH;
    return r;
  endfunction

  assign s_if.s_rdy = clk_en & ~hold_full_q;
  assign xfer       = s_if.s_vld & s_if.s_rdy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    load_sel    = LD_NONE;
    do_shift    = 1'b0;
    hold_wr     = 1'b0;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            load_sel = LD_BYPASS;
            cnt_d    = '0;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != LAST_CNT) begin
            do_shift = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (xfer) begin
              hold_wr     = 1'b1;
              hold_full_d = 1'b1;
            end
          end else if (hold_full_q) begin
            load_sel    = LD_HOLD;
            hold_full_d = 1'b0;
            cnt_d       = '0;
          end else if (xfer) begin
            load_sel = LD_BYPASS;
            cnt_d    = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
    end
  end

  // p0: shift register is cleared by reset so dout reads 0 while idle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_p0 <= '0;
    end else begin
      case (load_sel)
        LD_BYPASS: sreg_p0 <= extend_word(s_if.s_data);
        LD_HOLD:   sreg_p0 <= extend_word(hold_p0);
        default:   if (do_shift) sreg_p0 <= shift_lanes(sreg_p0);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (hold_wr) hold_p0 <= s_if.s_data;
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < INPUT_NUM; i++)
      dout[i*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH] = sreg_p0[i*LANE_W +: INPUT_DATA_WIDTH];
  end

  assign dout_vld       = (state_q == SHIFT);
  assign first_dout_vld = (state_q == SHIFT) && (cnt_q == '0);
  assign last_dout_vld  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign busy           = (state_q == SHIFT) | hold_full_q;

endmodule

// File: doc/channel_serializer.md
# channel_serializer

Upstream feeder for the channel adder tree. Accepts `INPUT_NUM` parallel channel words through a valid/ready handshake and converts each one into an LSB-first stream of `INPUT_DATA_WIDTH`-bit digits. All lanes shift in lockstep. The block drives the tree's `din`, `din_vld` and `first_din_vld` inputs directly. Each word is zero- or sign-extended with guard bits so that the tree's modular digit-serial sum over `INPUT_NUM` channels cannot overflow. A one-word holding buffer lets consecutive words stream with no bubble.

## Interface
- `INPUT_NUM`, 8: number of channels/lanes; must match the downstream tree.
- `INPUT_DATA_WIDTH`, 2: digit width; must match the downstream tree.
- `WORD_WIDTH`, 8: bits per channel word.
- `SIGNED`, 0: 0 = zero-extend, 1 = sign-extend (two's complement).
- Derived `GUARD` = clog2(`INPUT_NUM`).
- Derived `DIGITS` = ceil((`WORD_WIDTH`+`GUARD`)/`INPUT_DATA_WIDTH`). Defaults give 6.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_en` in 1: global stall. When 0, all state freezes and no handshake occurs.
- `s_vld` in 1: input word valid.
- `s_rdy` out 1: input ready.
- `s_data` in `INPUT_NUM`*`WORD_WIDTH`: lane i occupies bits [i*`WORD_WIDTH` +: `WORD_WIDTH`].
- `dout` out `INPUT_NUM`*`INPUT_DATA_WIDTH`: current digit of every lane, lane i at [i*`INPUT_DATA_WIDTH` +: `INPUT_DATA_WIDTH`]. Connects to the tree's `din`.
- `dout_vld` out 1: digit valid. Connects to the tree's `din_vld`.
- `first_dout_vld` out 1: high on digit 0 of a word. Connects to the tree's `first_din_vld`.
- `last_dout_vld` out 1: high on digit `DIGITS`-1 of a word.
- `busy` out 1: shift register or holding buffer occupied.

## Operation
- Storage:
  - Shift register holds `INPUT_NUM` lanes of `DIGITS`*`INPUT_DATA_WIDTH` bits.
  - Holding register holds one raw `s_data` word, with flag `hold_full`.
  - Digit counter `cnt` runs 0..`DIGITS`-1.
- FSM states: IDLE (shift register empty) and SHIFT (emitting digits).
- Handshake:
  - `s_rdy` = `clk_en` & ~`hold_full`, derived combinationally from registered state only.
  - A transfer occurs on a rising edge where `s_vld` & `s_rdy`.
- Load extension: when a word enters the shift register, each lane is extended to `DIGITS`*`INPUT_DATA_WIDTH` bits. Fill is 0 if `SIGNED`=0, or the lane MSB if `SIGNED`=1.
- Transitions (all evaluated only when `clk_en`=1):
  - IDLE + transfer: load the shift register from `s_data`, set `cnt`=0, go to SHIFT.
  - SHIFT, `cnt`<`DIGITS`-1: shift every lane right by `INPUT_DATA_WIDTH` and increment `cnt`. A transfer in this cycle writes the holding register and sets `hold_full`.
  - SHIFT, `cnt`=`DIGITS`-1, `hold_full`: move the holding register into the shift register (extended), clear `hold_full`, set `cnt`=0, stay in SHIFT.
  - SHIFT, `cnt`=`DIGITS`-1, ~`hold_full`, transfer: load `s_data` directly into the shift register (bypass), set `cnt`=0, stay in SHIFT.
  - SHIFT, `cnt`=`DIGITS`-1, no pending word: go to IDLE.
- No conflicts arise between the holding register and the bypass path: `s_rdy`=0 whenever `hold_full`=1.
- Outputs:
  - `dout` = low digit of each lane of the shift register.
  - `dout_vld` = (state==SHIFT).
  - `first_dout_vld` = SHIFT & `cnt`==0.
  - `last_dout_vld` = SHIFT & `cnt`==`DIGITS`-1.
  - All are direct functions of registers, with no path from `s_*` inputs.
  - `busy` = SHIFT | `hold_full`.
- With `clk_en`=0, every output holds its value and `s_rdy`=0. This matches the tree, which also freezes under `clk_en`.

## Timing
- Reset values (asynchronous, `rst_n`=0):
  - State IDLE, `cnt`=0, `hold_full`=0.
  - `dout`=0, `dout_vld`=0, `first_dout_vld`=0, `last_dout_vld`=0, `busy`=0.
  - `s_rdy` follows `clk_en` immediately.
- Latency: for a word accepted at edge N into an idle block, digit 0 is on `dout`, with `first_dout_vld`=1, during the cycle after edge N. Digit k appears after edge N+k.
- Throughput: one word per `DIGITS` enabled cycles. Back-to-back words produce a continuous `dout_vld` with `first_dout_vld` pulsing every `DIGITS` cycles.
- Accept-while-shifting: after one word is taken into the holding register, `s_rdy` drops until the last digit of the current word is consumed.
- Reset mid-word:
  - All state is discarded and `dout_vld` falls asynchronously.
  - The partially sent word is dropped.
  - The tree's own reset is expected to clear its carry state at the same time.
- `DIGITS`=1 is legal. In that case `first_dout_vld` and `last_dout_vld` are both high on every valid digit.

## Test plan
- Single word, defaults, `SIGNED`=0, lane0=0xB4, other lanes 0 → lane0 digits 0,1,3,2,0,0 over 6 cycles. `first_dout_vld` high on cycle 1 only, `last_dout_vld` high on cycle 6, then IDLE.
- Same stimulus with `SIGNED`=1 → lane0 digits 0,1,3,2,3,3.
- `s_vld` held high with 4 consecutive words → `dout_vld` continuously high for 24 cycles and `first_dout_vld` every 6th cycle. `s_rdy` pattern: accept, accept, then low until each slot frees. No word lost or duplicated.
- `clk_en` low for 3 cycles in the middle of a word → `dout`, flags and `cnt` frozen with `s_rdy`=0, and the word resumes intact afterwards.
- End-to-end with the tree: all 8 lanes = 0xFF, `SIGNED`=0 → the reassembled 12-bit tree output equals 8*255=2040. With `SIGNED`=1 and all lanes 0x80 → the result equals -1024 mod 4096.
- Assert `rst_n` at digit 3 while the holding register is full → all outputs and `busy` read 0 immediately. After release, the next accepted word streams from digit 0.
